// File: rtl/pipe_arb_pkg.sv
// rtl/pipe_arb_pkg.sv - shared types and widths for the pipeline memory-port arbiter
//
// Purpose: enums for transaction owner and FSM state, plus counter widths, used by
//          pipe_arb_pick and pipe_mem_arbiter.
package pipe_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Latency down-counter width; holds MEM_LAT-1 for MEM_LAT in 1..15.
    localparam int LAT_W = 4;

    // Width of the optional DM-streak counter.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/pipe_arb_pick.sv
// rtl/pipe_arb_pick.sv - winner selection between fetch and data-memory requests
//
// Purpose: picks which stage would win the memory port this cycle. Data memory beats
//          fetch (it belongs to the older instruction). With PIPE_ARB_STARVE_GUARD_EN
//          defined, a 4-bit counter tracks consecutive DM grants made while a fetch is
//          waiting; once it reaches STARVE_MAX the fetch is forced through.
//          Without the macro the selection is purely combinational (no flops).
// Ports:
//  clk      in   clock (counter only)
//  reset    in   asynchronous active-high reset
//  if_req   in   fetch request pending
//  dm_req   in   data request pending
//  if_gnt   in   fetch granted this cycle (feedback from the top)
//  dm_gnt   in   data granted this cycle (feedback from the top)
//  winner   out  OWN_IF / OWN_DM / OWN_NONE
module pipe_arb_pick
    import pipe_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   if_gnt,
    input  logic   dm_gnt,
    output owner_e winner
);

    logic force_if;

`ifdef PIPE_ARB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve_cnt;

    // A streak only matters while fetch keeps asking; serving fetch or fetch
    // withdrawing both end the streak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (dm_gnt) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_if = if_req && (starve_cnt == STARVE_W'(STARVE_MAX));
`else
    // Strict DM priority: the counter inputs are intentionally unused.
    logic unused_pick;
    assign unused_pick = ^{clk, reset, if_gnt, dm_gnt, STARVE_MAX[0]};
    assign force_if    = 1'b0;
`endif

    always_comb begin
        winner = OWN_NONE;
        if (dm_req && !force_if) begin
            winner = OWN_DM;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - shares one fixed-latency memory port between IF and DM
//
// Purpose: one transaction in flight at a time. In IDLE a pending request is granted
//          combinationally in the same cycle (DM over IF), the memory strobe is issued,
//          and a down-counter loaded with MEM_LAT-1 times the response. The owner's
//          rvalid pulses with mem_rdata passed straight through at grant+MEM_LAT.
//          Optional feature macro: PIPE_ARB_STARVE_GUARD_EN (see pipe_arb_pick).
// Ports:
//  clk, reset                         clock, asynchronous active-high reset
//  if_req, if_addr                    fetch request (held until if_gnt)
//  if_gnt, if_rvalid, if_rdata        fetch grant pulse, data valid pulse, data
//  dm_req, dm_we, dm_addr, dm_wdata   data request (held until dm_gnt)
//  dm_gnt, dm_rvalid, dm_rdata        data grant pulse, completion pulse, read data
//  mem_en, mem_we, mem_addr,
//  mem_wdata, mem_rdata               memory port (rdata valid MEM_LAT after mem_en)
//  busy                               grant cycle through rvalid cycle inclusive
module pipe_mem_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_e            state, state_n;
    owner_e            owner, owner_n;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;
    owner_e            winner;
    logic              grant;
    logic              done;

    pipe_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .dm_req (dm_req),
        .if_gnt (if_gnt),
        .dm_gnt (dm_gnt),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            lat_cnt <= '0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            lat_cnt <= lat_cnt_n;
        end
    end

    // Grant is gated by reset so that requests held high during reset see no
    // combinational grant leaking through the IDLE state.
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        lat_cnt_n = lat_cnt;
        grant     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!reset && (winner != OWN_NONE)) begin
                    grant     = 1'b1;
                    state_n   = ST_WAIT;
                    owner_n   = winner;
                    lat_cnt_n = LAT_W'(MEM_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                    owner_n = OWN_NONE;
                end else begin
                    lat_cnt_n = lat_cnt - 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                owner_n = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        if_gnt    = grant && (winner == OWN_IF);
        dm_gnt    = grant && (winner == OWN_DM);
        mem_en    = grant;
        mem_we    = dm_gnt && dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
        if_rvalid = done && (owner == OWN_IF);
        dm_rvalid = done && (owner == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
        busy      = grant || (state == ST_WAIT);
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - self-checking bench for pipe_mem_arbiter
module tb_pipe_mem_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    pipe_mem_arbiter #(
        .AW (AW), .DW (DW), .MEM_LAT (MEM_LAT), .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk), .reset (reset),
        .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt),
        .if_rvalid (if_rvalid), .if_rdata (if_rdata),
        .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
        .dm_gnt (dm_gnt), .dm_rvalid (dm_rvalid), .dm_rdata (dm_rdata),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] due [int];

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a      = '0;
        a[7:2] = 6'($urandom_range(0, 63));
        return a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    endtask

    // Transaction-level reference: who owns the port and the cycle its response is due.
    int            m_owner = 0;       // 0 none, 1 fetch, 2 data
    int            m_done  = 0;
    logic          m_we    = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_starve = 0;
    bit            preloaded = 0;

    always @(negedge clk) begin : cmp_p
        logic          e_gnt_if, e_gnt_dm, e_rv_if, e_rv_dm, e_busy, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        bit            pick_dm;
        if (!preloaded) begin
            mem[32'h10] = 32'hDEADBEEF;
            preloaded   = 1;
        end
        e_gnt_if = 0; e_gnt_dm = 0; e_rv_if = 0; e_rv_dm = 0; e_busy = 0; e_we = 0;
        e_addr = '0; e_wdata = '0; pick_dm = 0;
        if (!reset) begin
            if (m_owner != 0) begin
                e_busy = 1;
                if (cyc == m_done) begin
                    e_rv_if = (m_owner == 1);
                    e_rv_dm = (m_owner == 2);
                end
            end else if (if_req || dm_req) begin
                pick_dm = dm_req;
`ifdef PIPE_ARB_STARVE_GUARD_EN
                if (if_req && m_starve == STARVE_MAX) pick_dm = 0;
`endif
                e_busy = 1;
                if (pick_dm) begin
                    e_gnt_dm = 1; e_addr = dm_addr; e_wdata = dm_wdata; e_we = dm_we;
                end else begin
                    e_gnt_if = 1; e_addr = if_addr;
                end
            end
        end
        chk("busy", busy, e_busy);
        chk("if_gnt", if_gnt, e_gnt_if);
        chk("dm_gnt", dm_gnt, e_gnt_dm);
        chk("if_rvalid", if_rvalid, e_rv_if);
        chk("dm_rvalid", dm_rvalid, e_rv_dm);
        chk("mem_en", mem_en, e_gnt_if | e_gnt_dm);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        if (e_rv_if) chk("if_rdata", if_rdata, m_data);
        if (e_rv_dm && !m_we) chk("dm_rdata", dm_rdata, m_data);

        if (reset) begin
            m_owner  = 0;
            m_starve = 0;
        end else begin
            if (m_owner != 0 && cyc == m_done) begin
                m_owner = 0;
            end else if (e_gnt_if || e_gnt_dm) begin
                m_owner = e_gnt_dm ? 2 : 1;
                m_done  = cyc + MEM_LAT;
                m_we    = e_we;
                m_data  = mem_rd(e_addr);
            end
            if (!if_req || e_gnt_if) m_starve = 0;
            else if (e_gnt_dm) m_starve++;
        end

        // Memory model, driven from the DUT's port.
        if (!reset && mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else due[cyc + MEM_LAT] = mem_rd(mem_addr);
        end
        if (due.exists(cyc + 1)) begin
            mem_rdata = due[cyc + 1];
            due.delete(cyc + 1);
        end else begin
            mem_rdata = $urandom;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ig, dg;
        int   n_if, n_dm;

        // Reset held three cycles with both requests high.
        if_req = 1; dm_req = 1; if_addr = 32'h80; dm_addr = 32'h84;
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", busy, 1'b0);
            chk("rst_gnt", {if_gnt, dm_gnt}, 2'b00);
            chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
            chk("rst_rv", {if_rvalid, dm_rvalid, if_rdata, dm_rdata}, '0);
        end
        step(); reset = 0;
        @(negedge clk); chk("first_dm_gnt", {dm_gnt, if_gnt, mem_en}, 3'b101);
        step(); dm_req = 0;
        step(); step();
        @(negedge clk); chk("first_if_gnt", if_gnt, 1'b1);
        step(); if_req = 0;
        repeat (3) step();

        // Single fetch.
        if_req = 1; if_addr = 32'h10;
        @(negedge clk); chk("t2_gnt", {if_gnt, mem_en, busy}, 3'b111);
        chk("t2_addr", mem_addr, 32'h10);
        step(); if_req = 0;
        @(negedge clk); chk("t2_busy1", busy, 1'b1);
        step();
        @(negedge clk); chk("t2_rvalid", {if_rvalid, busy}, 2'b11);
        chk("t2_rdata", if_rdata, 32'hDEADBEEF);
        step();
        @(negedge clk); chk("t2_idle", busy, 1'b0);
        step();

        // Simultaneous requests: DM first, IF three cycles later.
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
        @(negedge clk); chk("t3_dm_gnt", {dm_gnt, if_gnt}, 2'b10);
        step(); dm_req = 0;
        step();
        @(negedge clk); chk("t3_dm_rv", dm_rvalid, 1'b1);
        step();
        @(negedge clk); chk("t3_if_gnt", if_gnt, 1'b1);
        step(); if_req = 0;
        step();
        @(negedge clk); chk("t3_if_rv", if_rvalid, 1'b1);
        step(); step();

        // Write.
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h1234;
        @(negedge clk); chk("t4_we", {mem_en, mem_we}, 2'b11);
        chk("t4_addr", mem_addr, 32'h40);
        chk("t4_wdata", mem_wdata, 32'h1234);
        step(); dm_req = 0; dm_we = 0;
        step();
        @(negedge clk); chk("t4_done", dm_rvalid, 1'b1);
        chk("t4_mem", mem_rd(32'h40), 32'h1234);
        step(); step();

        // Both held for 20 cycles.
        n_if = 0; n_dm = 0;
        if_req = 1; dm_req = 1; dm_we = 0; if_addr = 32'h10; dm_addr = 32'h20;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_gnt) n_if++;
            if (dm_gnt) n_dm++;
            step();
        end
`ifdef PIPE_ARB_STARVE_GUARD_EN
        chk("t5_if_cnt", n_if, 1);
        chk("t5_dm_cnt", n_dm, 6);
`else
        chk("t5_if_cnt", n_if, 0);
        chk("t5_dm_cnt", n_dm, 7);
`endif
        if_req = 0; dm_req = 0;
        repeat (4) step();

        // Reset mid-transaction.
        dm_req = 1; dm_we = 0; dm_addr = 32'h20;
        @(negedge clk); chk("t6_gnt", dm_gnt, 1'b1);
        step(); dm_req = 0; reset = 1;
        @(negedge clk); chk("t6_rst", {busy, mem_en, dm_rvalid}, 3'b000);
        step(); reset = 0;
        @(negedge clk); chk("t6_no_rv", {dm_rvalid, busy}, 2'b00);
        step(); if_req = 1; if_addr = 32'h10;
        @(negedge clk); chk("t6_if_gnt", if_gnt, 1'b1);
        step(); if_req = 0;
        step();
        @(negedge clk); chk("t6_if_rv", if_rvalid, 1'b1);
        chk("t6_if_rdata", if_rdata, 32'hDEADBEEF);
        step(); step();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ig = if_gnt;
            dg = dm_gnt;
            step();
            if (reset) begin
                reset = 0;
            end else if ($urandom_range(0, 599) == 0) begin
                reset = 1; if_req = 0; dm_req = 0;
                continue;
            end
            if (ig) begin
                if ($urandom_range(0, 1) == 1) if_addr = rand_addr();
                else if_req = 0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = rand_addr();
            end
            if (dg) begin
                if ($urandom_range(0, 1) == 1) begin
                    dm_addr = rand_addr(); dm_we = 1'($urandom); dm_wdata = $urandom;
                end else begin
                    dm_req = 0;
                end
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_addr = rand_addr(); dm_we = 1'($urandom); dm_wdata = $urandom;
            end
        end
        if_req = 0; dm_req = 0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
